stream_mux: RTL and testbench
=============================

# stream_mux

Registered, parametrised N-channel, W-bit stream multiplexer for the CPU datapath. It supersedes the combinational 4:1 selector. Channels hand data over with a valid/ready handshake, a one-entry output register holds the result, and the grant is chosen either by an explicit select or by round-robin arbitration. It keeps the complemented output of the earlier selector as a registered data_n bus. It sits between multiple producers (register-file read ports, ALU, load unit) and a single consumer stage.

## Interface
Parameters:
- WIDTH, 8: data width per channel.
- CHANNELS, 4: number of input channels, ≥2.
- SEL_W: localparam, $clog2(CHANNELS); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_valid  input  CHANNELS  per-channel valid.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel accept; at most one bit set.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  selected data.
- out_data_n  output  WIDTH  bitwise complement of out_data, registered.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts.

Clock and reset: one clock domain; reset is synchronous and active-low. Ports are clk and rst_n.

## Operation
- Two states, tracked by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = ~out_valid | out_ready.
- Grant in fixed mode:
  - grant = channel sel, if sel < CHANNELS and in_valid[sel]=1.
  - Otherwise no grant. An out-of-range sel never grants.
- Grant in round-robin mode:
  - Scan from ptr upward, modulo CHANNELS.
  - Grant the first channel with in_valid set.
- in_ready[i] = load_en & grant[i]. It is combinational from in_valid, sel, mode, ptr, out_valid and out_ready.
- A transfer on channel g occurs when in_valid[g] & in_ready[g]. On the next edge:
  - out_data ← in_data[g]
  - out_data_n ← ~in_data[g]
  - out_chan ← g
  - out_valid ← 1
- When out_ready=1 and no transfer occurs, out_valid ← 0 (FULL→EMPTY). The data registers hold their value.
- ptr ← (g+1) mod CHANNELS on every transfer, in either mode. ptr is not touched by a mode change.
- While FULL and out_ready=0, every output is stable and in_ready is all zero.

## Timing
- Reset values: out_valid=0, out_data=0, out_data_n=all ones, out_chan=0, ptr=0. in_ready is all zero during reset.
- Latency: one cycle from input transfer to out_valid=1.
- Throughput: one word per cycle while out_ready=1 and a grant exists. Simultaneous drain and load in FULL keeps out_valid=1 with the new data.
- mode and sel are sampled combinationally each cycle. A change applies to the next grant only and never alters the registered output.
- Reset asserted mid-stream discards the held word at the next edge.
- CHANNELS not a power of two: ptr wraps at CHANNELS-1 → 0.

## Structure
- Package stream_mux_pkg holds the MODE_FIXED and MODE_RR constants.
- Sub-module rr_arbiter (CHANNELS parameter):
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- ptr and the output register live in stream_mux.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1. Required: out_valid=0, out_data=0x00, out_data_n=0xFF, in_ready=0.
- Fixed mode: mode=0, sel=2, in_data ch2=0xA5, all valid, out_ready=1. Required: in_ready=4'b0100; next cycle out_data=0xA5, out_data_n=0x5A, out_chan=2.
- Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1. Required: out_chan sequence 0,1,2,3,0 on consecutive cycles.
- Backpressure: load a word, then hold out_ready=0 for 4 cycles. Required: out_data stable and in_ready=0. On release, the new word loads in the same cycle the old one drains.
- Sparse round-robin: mode=1, only ch1 and ch3 valid, ptr=2. Required: grant ch3, then ch1, then ch3.
- CHANNELS=3 instance: sel=3 never grants. Round-robin wraps 2→0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and state encoding for the registered stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo CHANNELS.
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx,
  output logic                any
);

  // Candidate index is compared against constants so every req/grant select stays static.
  always_comb begin : scan
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      for (int j = 0; j < CHANNELS; j++) begin
        if (!any && (j == cand) && req[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = SEL_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a one-entry output register,
// fixed-select or round-robin grant, and a registered complemented data bus.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [WIDTH-1:0]          out_data_n,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  state_t                state;
  logic [SEL_W-1:0]      ptr;
  logic [CHANNELS-1:0]   arb_grant;
  logic [SEL_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [CHANNELS-1:0]   fixed_grant;
  logic [CHANNELS-1:0]   grant;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [WIDTH-1:0]      grant_data;
  logic                  load_en;
  logic                  transfer;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // An out-of-range sel matches no channel, so it can never grant.
  always_comb begin
    fixed_grant = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if ((int'(sel) == j) && in_valid[j]) fixed_grant[j] = 1'b1;
    end
  end

  assign grant     = (mode == MODE_RR) ? arb_grant : fixed_grant;
  assign grant_idx = (mode == MODE_RR) ? arb_idx   : sel;
  assign grant_any = (mode == MODE_RR) ? arb_any   : |fixed_grant;

  always_comb begin
    grant_data = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (grant[j]) grant_data = in_data[j*WIDTH +: WIDTH];
    end
  end

  assign out_valid = (state == ST_FULL);
  assign load_en   = ~out_valid | out_ready;
  assign transfer  = rst_n & load_en & grant_any;
  assign in_ready  = (rst_n && load_en) ? grant : '0;

  // Load on any transfer; otherwise a drained FULL register goes EMPTY and keeps its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      out_data   <= '0;
      out_data_n <= '1;
      out_chan   <= '0;
      ptr        <= '0;
    end else if (transfer) begin
      state      <= ST_FULL;
      out_data   <= grant_data;
      out_data_n <= ~grant_data;
      out_chan   <= grant_idx;
      ptr        <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
    end else if (out_ready) begin
      state      <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: 4-channel and 3-channel instances checked every
// cycle against a queue-free behavioural model, plus hand-computed directed expectations.
module tb_stream_mux;
  import stream_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        mode4, or4, ov4;
  logic [1:0]  sel4, oc4;
  logic [3:0]  valid4, ready4;
  logic [31:0] data4;
  logic [7:0]  od4, odn4;

  logic        mode3, or3, ov3;
  logic [1:0]  sel3, oc3;
  logic [2:0]  valid3, ready3;
  logic [23:0] data3;
  logic [7:0]  od3, odn3;

  int n_checks = 0;
  int n_fail   = 0;

  stream_mux #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4), .in_valid(valid4),
    .in_data(data4), .in_ready(ready4), .out_valid(ov4), .out_data(od4),
    .out_data_n(odn4), .out_chan(oc4), .out_ready(or4)
  );

  stream_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_valid(valid3),
    .in_data(data3), .in_ready(ready3), .out_valid(ov3), .out_data(od3),
    .out_data_n(odn3), .out_chan(oc3), .out_ready(or3)
  );

  typedef struct {
    bit         valid;
    logic [7:0] data;
    int         chan;
    int         ptr;
  } model_t;

  model_t m4, m3;
  bit     model_live = 1'b0;

  // Channel that wins this cycle, or -1 when nobody is granted.
  function automatic int pick(int n, logic md, int s, logic [3:0] v, int p);
    if (md == MODE_FIXED) begin
      if (s < n && v[s]) return s;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic model_t advance(model_t s, logic rst, logic md, int sl, logic [3:0] v,
                                     logic [31:0] d, logic ordy, int n);
    model_t r = s;
    int g;
    if (!rst) begin
      r.valid = 1'b0; r.data = 8'h00; r.chan = 0; r.ptr = 0;
      return r;
    end
    g = pick(n, md, sl, v, s.ptr);
    if ((!s.valid || ordy) && g >= 0) begin
      r.valid = 1'b1; r.data = d[g*8 +: 8]; r.chan = g; r.ptr = (g + 1) % n;
    end else if (ordy) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [3:0] ready_of(model_t s, logic rst, logic md, int sl, logic [3:0] v,
                                          logic ordy, int n);
    int g;
    g = pick(n, md, sl, v, s.ptr);
    if (rst && (!s.valid || ordy) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic md, input logic [1:0] s,
                               input logic [3:0] v, input logic ordy);
    rst_n  = rst;
    mode4  = md;
    sel4   = s;
    valid4 = v;
    or4    = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model state follows the same edge the DUT registers on.
  always @(posedge clk) begin
    m4 = advance(m4, rst_n, mode4, int'(sel4), valid4, data4, or4, 4);
    m3 = advance(m3, rst_n, mode3, int'(sel3), {1'b0, valid3}, {8'h00, data3}, or3, 3);
    if (!rst_n) model_live = 1'b1;
  end

  always @(negedge clk) begin
    logic [7:0] exp_n4, exp_n3;
    if (model_live) begin
      exp_n4 = ~m4.data;
      exp_n3 = ~m3.data;
      checkOutput("m4_out_valid",  ov4,    m4.valid);
      checkOutput("m4_out_data",   od4,    m4.data);
      checkOutput("m4_out_data_n", odn4,   exp_n4);
      checkOutput("m4_out_chan",   oc4,    m4.chan);
      checkOutput("m4_in_ready",   ready4, ready_of(m4, rst_n, mode4, int'(sel4), valid4, or4, 4));
      checkOutput("m3_out_valid",  ov3,    m3.valid);
      checkOutput("m3_out_data",   od3,    m3.data);
      checkOutput("m3_out_data_n", odn3,   exp_n3);
      checkOutput("m3_out_chan",   oc3,    m3.chan);
      checkOutput("m3_in_ready",   ready3, ready_of(m3, rst_n, mode3, int'(sel3), {1'b0, valid3}, or3, 3));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rr_seq[5]     = '{0, 1, 2, 3, 0};
    int sparse_seq[3] = '{3, 1, 3};
    int wrap_seq[4]   = '{0, 1, 2, 0};

    data4 = {8'h44, 8'hA5, 8'h22, 8'h11};
    data3 = {8'h33, 8'h32, 8'h31};
    mode3 = MODE_FIXED; sel3 = 2'd0; valid3 = 3'b000; or3 = 1'b1;
    applyStimulus(1'b0, MODE_FIXED, 2'd0, 4'hF, 1'b1);

    repeat (3) step();
    checkOutput("rst_out_valid",  ov4,    32'h0);
    checkOutput("rst_out_data",   od4,    32'h00);
    checkOutput("rst_out_data_n", odn4,   32'hFF);
    checkOutput("rst_in_ready",   ready4, 32'h0);

    applyStimulus(1'b1, MODE_FIXED, 2'd2, 4'hF, 1'b1);
    #1;
    checkOutput("fixed_in_ready", ready4, 32'b0100);
    step();
    checkOutput("fixed_out_data",   od4,  32'hA5);
    checkOutput("fixed_out_data_n", odn4, 32'h5A);
    checkOutput("fixed_out_chan",   oc4,  32'd2);
    checkOutput("fixed_out_valid",  ov4,  32'd1);

    // Mid-stream reset drops the held word and returns ptr to 0.
    applyStimulus(1'b0, MODE_RR, 2'd0, 4'hF, 1'b1);
    step();
    checkOutput("midrst_out_valid", ov4, 32'd0);
    checkOutput("midrst_out_data",  od4, 32'h00);

    applyStimulus(1'b1, MODE_RR, 2'd0, 4'hF, 1'b1);
    #1;
    checkOutput("rr_first_ready", ready4, 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("rr_out_chan", oc4, rr_seq[i]);
    end

    applyStimulus(1'b1, MODE_RR, 2'd0, 4'hF, 1'b0);
    #1;
    checkOutput("bp_in_ready", ready4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("bp_out_data",  od4,    32'h11);
      checkOutput("bp_out_chan",  oc4,    32'd0);
      checkOutput("bp_hold_ready", ready4, 32'h0);
      if (i == 1) applyStimulus(1'b1, MODE_FIXED, 2'd3, 4'hF, 1'b0);
    end
    applyStimulus(1'b1, MODE_RR, 2'd0, 4'hF, 1'b1);
    #1;
    checkOutput("bp_release_ready", ready4, 32'b0010);
    step();
    checkOutput("bp_release_data",  od4, 32'h22);
    checkOutput("bp_release_chan",  oc4, 32'd1);
    checkOutput("bp_release_valid", ov4, 32'd1);

    applyStimulus(1'b1, MODE_RR, 2'd0, 4'b1010, 1'b1);
    #1;
    checkOutput("sparse_first_ready", ready4, 32'b1000);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("sparse_out_chan", oc4, sparse_seq[i]);
    end

    applyStimulus(1'b1, MODE_RR, 2'd0, 4'b0000, 1'b1);
    step();
    checkOutput("drain_out_valid", ov4, 32'd0);
    checkOutput("drain_data_held", od4, 32'h44);

    mode3 = MODE_FIXED; sel3 = 2'd3; valid3 = 3'b111;
    #1;
    checkOutput("c3_sel3_ready", ready3, 32'h0);
    step();
    checkOutput("c3_sel3_valid", ov3, 32'd0);

    mode3 = MODE_RR;
    #1;
    checkOutput("c3_rr_first_ready", ready3, 32'b001);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("c3_wrap_chan", oc3, wrap_seq[i]);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
